stream_cipher_pipe: RTL and testbench

Parametrised LFSR stream cipher with valid/ready streaming interfaces, the successor to the fixed 8-bit `stream_cypher` tile. It XORs each accepted input word with a keystream word taken from a Galois LFSR. It supports a loadable key, OFB and CFB modes, and encrypt/decrypt direction. It sits between the pad/IO adapter and the output mux, with a one-word registered output stage and full backpressure.

---
 rtl/stream_cipher_pipe.sv | 93 +++++++++
 tb/tb_stream_cipher_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_cipher_pipe.sv
// LFSR stream cipher: XORs each accepted word with a Galois-LFSR keystream word
// (OFB or CFB feedback) and holds the result in a single backpressured output register.
module stream_cipher_pipe #(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              key_load,
  input  logic [LFSR_W-1:0] key_in,
  input  logic              mode,
  input  logic              dir,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  word_count
);

  typedef struct packed {
    logic [LFSR_W-1:0] lfsr;
    logic [DATA_W-1:0] data;
    logic              vld;
    logic [CNT_W-1:0]  cnt;
  } state_t;

  state_t st_q, st_d;

  logic              accept, pop, do_load;
  logic [DATA_W-1:0] ks, word;
  logic [DATA_W-1:0] fb;
  logic [LFSR_W-1:0] stepped, nxt_lfsr, load_lfsr;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // An all-zero LFSR state would lock up; SEED stands in for it everywhere.
  function automatic logic [LFSR_W-1:0] nz_guard(input logic [LFSR_W-1:0] s);
    return (s == '0) ? SEED : s;
  endfunction

  assign do_load  = ena && key_load;
  assign in_ready = ena && !key_load && (!st_q.vld || out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = ena && st_q.vld && out_ready;

  assign ks        = st_q.lfsr[DATA_W-1:0];
  assign word      = in_data ^ ks;
  // CFB feeds back the ciphertext side: our output when encrypting, our input when decrypting.
  assign fb        = dir ? word : in_data;
  assign stepped   = lfsr_step(st_q.lfsr);
  assign nxt_lfsr  = nz_guard(stepped ^ (mode ? LFSR_W'(fb) : '0));
  assign load_lfsr = nz_guard(key_in);

  always_comb begin
    st_d = st_q;
    if (do_load) begin
      st_d.lfsr = load_lfsr;
      st_d.cnt  = '0;
      st_d.vld  = 1'b0;
    end else if (accept) begin
      st_d.lfsr = nxt_lfsr;
      st_d.data = word;
      st_d.vld  = 1'b1;
      st_d.cnt  = st_q.cnt + 1'b1;
    end else if (pop) begin
      st_d.vld  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q.lfsr <= SEED;
      st_q.data <= '0;
      st_q.vld  <= 1'b0;
      st_q.cnt  <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign out_valid  = st_q.vld;
  assign out_data   = st_q.data;
  assign word_count = st_q.cnt;

endmodule

// File: tb/tb_stream_cipher_pipe.sv
// Directed test-plan vectors followed by randomized traffic checked against a
// cycle-level reference model of the cipher built from plain integer arithmetic.
module tb_stream_cipher_pipe;

  localparam int          DW   = 8;
  localparam int          LW   = 16;
  localparam int unsigned TAPS = 32'hB400;
  localparam int unsigned SEED = 32'hACE1;

  logic          clk = 1'b0;
  logic          rst_n, ena, key_load, mode, dir, in_valid, out_ready;
  logic [LW-1:0] key_in;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [15:0]   word_count;

  int n_chk = 0;
  int n_err = 0;

  stream_cipher_pipe dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .key_load(key_load), .key_in(key_in),
    .mode(mode), .dir(dir), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [LW-1:0] k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
  endtask

  // Offer one word, wait (bounded) for in_ready, let the accepting edge pass.
  task automatic send(input logic [DW-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  function automatic int unsigned ref_step(input int unsigned s);
    return (s >> 1) ^ ((s % 2 == 1) ? TAPS : 0);
  endfunction

  // Reference model state
  int unsigned m_lfsr, m_cnt, m_od;
  bit          m_ov;

  initial begin
    rst_n = 1'b0; ena = 1'b1; key_load = 1'b0; key_in = '0; mode = 1'b0; dir = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // OFB encrypt
    send(8'hFF); chk("ofb_enc0", {24'd0, out_data}, 32'h1E);
    chk("ofb_enc0_vld", {31'd0, out_valid}, 32'd1);
    send(8'h00); chk("ofb_enc1", {24'd0, out_data}, 32'h70);
    chk("ofb_cnt", {16'd0, word_count}, 32'd2);

    // OFB decrypt
    load_key(16'hACE1);
    chk("load_vld", {31'd0, out_valid}, 32'd0);
    chk("load_cnt", {16'd0, word_count}, 32'd0);
    send(8'h1E); chk("ofb_dec0", {24'd0, out_data}, 32'hFF);
    send(8'h70); chk("ofb_dec1", {24'd0, out_data}, 32'h00);

    // CFB encrypt then decrypt
    load_key(16'hACE1); mode = 1'b1; dir = 1'b1;
    send(8'hFF); chk("cfb_enc0", {24'd0, out_data}, 32'h1E);
    send(8'h00); chk("cfb_enc1", {24'd0, out_data}, 32'h6E);
    load_key(16'hACE1); dir = 1'b0;
    send(8'h1E); chk("cfb_dec0", {24'd0, out_data}, 32'hFF);
    send(8'h6E); chk("cfb_dec1", {24'd0, out_data}, 32'h00);

    // Zero key falls back to SEED
    load_key(16'h0000); mode = 1'b0; dir = 1'b1;
    send(8'h00); chk("zero_key", {24'd0, out_data}, 32'hE1);

    // Backpressure, then simultaneous pop and accept
    load_key(16'hACE1); out_ready = 1'b0;
    send(8'hFF); chk("bp_hold0", {24'd0, out_data}, 32'h1E);
    in_valid = 1'b1; in_data = 8'h00; #1;
    chk("bp_not_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_hold1", {24'd0, out_data}, 32'h1E);
    chk("bp_vld", {31'd0, out_valid}, 32'd1);
    chk("bp_cnt", {16'd0, word_count}, 32'd1);
    out_ready = 1'b1; #1;
    chk("bp_ready", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    chk("bp_next", {24'd0, out_data}, 32'h70);
    chk("bp_next_vld", {31'd0, out_valid}, 32'd1);
    chk("bp_cnt2", {16'd0, word_count}, 32'd2);
    tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // ena low freezes a held word
    out_ready = 1'b0; send(8'h5A);
    ena = 1'b0; out_ready = 1'b1; #1;
    chk("ena_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("ena_vld", {31'd0, out_valid}, 32'd1);
    chk("ena_cnt", {16'd0, word_count}, 32'd3);
    ena = 1'b1; out_ready = 1'b0;

    // key_load flushes a pending word
    load_key(16'h1234);
    chk("flush_vld", {31'd0, out_valid}, 32'd0);
    chk("flush_cnt", {16'd0, word_count}, 32'd0);

    // Async reset mid-stream
    send(8'h55);
    chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("async_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("async_rst_data", {24'd0, out_data}, 32'h00);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    send(8'hFF); chk("post_rst", {24'd0, out_data}, 32'h1E);

    // Randomized traffic against the reference model
    begin
      int unsigned k;
      k = $urandom_range(0, 65535);
      load_key(k[15:0]);
      m_lfsr = (k == 0) ? SEED : k;
      m_cnt = 0; m_ov = 0; m_od = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int unsigned ks, w, nx;
      bit rdy, acc, pop;
      ena       = ($urandom_range(0, 9) != 0);
      key_load  = ($urandom_range(0, 49) == 0);
      key_in    = LW'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 65535));
      mode      = 1'($urandom_range(0, 1));
      dir       = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      rdy = ena && !key_load && (!m_ov || out_ready);
      chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, rdy});
      tick();
      if (ena) begin
        if (key_load) begin
          m_lfsr = (key_in == 0) ? SEED : key_in;
          m_cnt = 0; m_ov = 0;
        end else begin
          acc = in_valid && rdy;
          pop = m_ov && out_ready;
          if (acc) begin
            ks = m_lfsr % 256;
            w  = in_data ^ ks;
            nx = ref_step(m_lfsr);
            if (mode) nx = nx ^ (dir ? w : in_data);
            m_lfsr = (nx == 0) ? SEED : nx;
            m_od = w; m_ov = 1;
            m_cnt = (m_cnt + 1) % 65536;
          end else if (pop) begin
            m_ov = 0;
          end
        end
      end
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("rnd_word_count", {16'd0, word_count}, m_cnt);
      if (m_ov) chk("rnd_out_data", {24'd0, out_data}, m_od);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
